// File: rtl/input_buffer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_buffer_ctrl_pkg
// Description : Shared sizing constants and reader state encoding for the
//               ping-pong input buffer controller.
// Revision    : 1.0 - initial release
// ============================================================================
package input_buffer_ctrl_pkg;

    localparam int DWIDTH  = 12;   // word width
    localparam int AWIDTH  = 10;   // full buffer address width
    localparam int BANK_AW = 9;    // per-bank address width (AWIDTH-1)

    // Reader state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

`default_nettype wire

// File: rtl/ibuf_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ibuf_skid_fifo
// Description : 2-entry output FIFO carrying {data, idx, last}. The head
//               entry drives the outputs directly, so they hold while the
//               consumer stalls.
// Ports       : clk, rstn          - clock, async active-low reset
//               push, push_*       - write side (caller guarantees space)
//               pop                - consumer accepted the head entry
//               count              - current occupancy 0..2
//               out_valid/data/idx/last - head entry
// Revision    : 1.0 - initial release
// ============================================================================
module ibuf_skid_fifo
    import input_buffer_ctrl_pkg::*;
#(
    parameter int DW = DWIDTH,
    parameter int IW = BANK_AW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic [IW-1:0] push_idx,
    input  logic          push_last,
    input  logic          pop,
    output logic [1:0]    count,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [IW-1:0] out_idx,
    output logic          out_last
);

    logic [1:0]    r_count;
    logic [DW-1:0] r_h_data, r_t_data;
    logic [IW-1:0] r_h_idx,  r_t_idx;
    logic          r_h_last, r_t_last;
    logic          w_pop;
    logic          w_push;

    assign w_pop  = pop && (r_count != 2'd0);
    assign w_push = push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count  <= 2'd0;
            r_h_data <= '0;
            r_h_idx  <= '0;
            r_h_last <= 1'b0;
            r_t_data <= '0;
            r_t_idx  <= '0;
            r_t_last <= 1'b0;
        end else begin
            // Tail advances into head when the head leaves a full FIFO
            if (w_pop && (r_count == 2'd2)) begin
                r_h_data <= r_t_data;
                r_h_idx  <= r_t_idx;
                r_h_last <= r_t_last;
            end
            if (w_push) begin
                if ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)) begin
                    r_h_data <= push_data;
                    r_h_idx  <= push_idx;
                    r_h_last <= push_last;
                end else begin
                    r_t_data <= push_data;
                    r_t_idx  <= push_idx;
                    r_t_last <= push_last;
                end
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign count     = r_count;
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_h_data;
    assign out_idx   = r_h_idx;
    assign out_last  = r_h_last;

endmodule

`default_nettype wire

// File: rtl/input_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : input_buffer_ctrl
// Description : Ping-pong tile buffer controller. A loader writes incoming
//               tiles into alternating banks of an external RAM; a reader
//               streams full banks out through a 2-entry skid FIFO,
//               optionally dropping zero words (never the tile's last word).
// Ports       : clk, rstn                    - clock, async active-low reset
//               tile_len, skip_en            - tile configuration
//               in_valid/in_ready/in_data    - load stream
//               out_valid/out_ready/out_*    - output stream
//               bank_full                    - per-bank full flags
//               ram_*0                       - RAM write port
//               ram_*1, ram_q1               - RAM read port (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module input_buffer_ctrl #(
    parameter int DWIDTH  = input_buffer_ctrl_pkg::DWIDTH,
    parameter int AWIDTH  = input_buffer_ctrl_pkg::AWIDTH,
    parameter int BANK_AW = input_buffer_ctrl_pkg::BANK_AW
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [BANK_AW:0]   tile_len,
    input  logic               skip_en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DWIDTH-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DWIDTH-1:0]  out_data,
    output logic [BANK_AW-1:0] out_idx,
    output logic               out_last,
    output logic [1:0]         bank_full,
    output logic [AWIDTH-1:0]  ram_addr0,
    output logic               ram_ce0,
    output logic               ram_we0,
    output logic [DWIDTH-1:0]  ram_d0,
    output logic [AWIDTH-1:0]  ram_addr1,
    output logic               ram_ce1,
    output logic               ram_we1,
    input  logic [DWIDTH-1:0]  ram_q1
);

    import input_buffer_ctrl_pkg::*;

    // ---------------- loader ----------------
    logic                   r_wr_bank;
    logic [BANK_AW-1:0]     r_wr_cnt;
    logic [1:0][BANK_AW:0]  r_len;
    logic [1:0]             r_bank_full;
    logic [BANK_AW:0]       w_wr_len;
    logic                   w_wr_fire;
    logic                   w_wr_last;

    // First word of a tile uses the live tile_len; later words the latched one
    assign w_wr_len  = (r_wr_cnt == '0) ? tile_len : r_len[r_wr_bank];
    assign w_wr_last = ({1'b0, r_wr_cnt} == (w_wr_len - 1'b1));
    // Held low during reset so no write can slip out before release
    assign in_ready  = rstn && !r_bank_full[r_wr_bank];
    assign w_wr_fire = in_valid && in_ready;

    assign ram_ce0   = w_wr_fire;
    assign ram_we0   = w_wr_fire;
    assign ram_addr0 = {r_wr_bank, r_wr_cnt};
    assign ram_d0    = in_data;

    // ---------------- reader ----------------
    logic [1:0]         r_state, w_next;
    logic               r_rd_bank;
    logic [BANK_AW-1:0] r_rd_cnt;
    logic               r_infl;
    logic [BANK_AW-1:0] r_infl_idx;
    logic               r_infl_last;
    logic [1:0]         w_occ;
    logic               w_pop;
    logic [2:0]         w_load;
    logic               w_issue;
    logic               w_rd_last;
    logic               w_push;

    assign w_pop     = out_valid && out_ready;
    // Entries that will be held after this cycle: queued + arriving - leaving
    assign w_load    = {1'b0, w_occ} + {2'b0, r_infl} - {2'b0, w_pop};
    assign w_rd_last = ({1'b0, r_rd_cnt} == (r_len[r_rd_bank] - 1'b1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (r_bank_full[r_rd_bank]) w_next = ST_READ;
            ST_READ:  if (w_issue && w_rd_last)   w_next = ST_DRAIN;
            ST_DRAIN: if ((w_occ == 2'd0) && !r_infl) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_issue = (r_state == ST_READ) && (w_load < 3'd2);
    end

    assign ram_ce1   = w_issue;
    assign ram_we1   = 1'b0;
    assign ram_addr1 = {r_rd_bank, r_rd_cnt};

    // Zero words are dropped when skipping, but a tile's last word always goes
    assign w_push = r_infl && !(skip_en && (ram_q1 == '0) && !r_infl_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_bank   <= 1'b0;
            r_wr_cnt    <= '0;
            r_len       <= '0;
            r_bank_full <= 2'b00;
            r_rd_bank   <= 1'b0;
            r_rd_cnt    <= '0;
            r_infl      <= 1'b0;
            r_infl_idx  <= '0;
            r_infl_last <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                if (r_wr_cnt == '0) r_len[r_wr_bank] <= tile_len;
                if (w_wr_last) begin
                    r_wr_cnt  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_cnt  <= r_wr_cnt + 1'b1;
                end
            end
            // Set and clear never target the same bank: a full bank blocks the loader
            r_bank_full <= (r_bank_full | ({1'b0, w_wr_fire && w_wr_last} << r_wr_bank))
                         & ~({1'b0, w_issue && w_rd_last} << r_rd_bank);

            if ((r_state == ST_IDLE) && r_bank_full[r_rd_bank]) r_rd_cnt <= '0;
            if (w_issue) begin
                if (w_rd_last) begin
                    r_rd_cnt  <= '0;
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_rd_cnt  <= r_rd_cnt + 1'b1;
                end
            end
            r_infl      <= w_issue;
            r_infl_idx  <= r_rd_cnt;
            r_infl_last <= w_rd_last;
        end
    end

    assign bank_full = r_bank_full;

    ibuf_skid_fifo #(
        .DW (DWIDTH),
        .IW (BANK_AW)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (w_push),
        .push_data (ram_q1),
        .push_idx  (r_infl_idx),
        .push_last (r_infl_last),
        .pop       (w_pop),
        .count     (w_occ),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

endmodule

`default_nettype wire
